// File: rtl/instr_feeder.sv
// instr_feeder: holds a small program and feeds it word-by-word to a processor,
// issuing one instruction at a time and waiting for the processor's done strobe.
module instr_feeder #(
  parameter int TIMEOUT = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_en,
  input  logic [4:0] load_addr,
  input  logic [8:0] load_data,
  input  logic       start,
  input  logic       done,
  output logic       run,
  output logic [8:0] DIN,
  output logic [4:0] pc,
  output logic       busy,
  output logic       halted,
  output logic       err,
  output logic [7:0] instr_count
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_IMM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [2:0] OP_IMM  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  logic [8:0]       mem_q [32];
  logic [2:0]       state_q, state_d;
  logic [4:0]       pc_q, pc_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       count_q, count_d;
  logic             err_q, err_d;
  logic             mem_we;
  logic             count_inc;
  logic [8:0]       word;

  // Current word is an asynchronous read at the program counter.
  assign word = mem_q[pc_q];

  // Next-state, output and bookkeeping logic for the fetch/issue FSM.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wrap_d    = wrap_q;
    cnt_d     = cnt_q;
    count_d   = count_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    count_inc = 1'b0;
    run       = 1'b0;
    DIN       = '0;
    case (state_q)
      S_IDLE, S_HALT: begin
        // Program memory is only writable while nothing is executing.
        mem_we = load_en;
        if (start) begin
          pc_d    = '0;
          wrap_d  = 1'b0;
          count_d = '0;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wrap_q) begin
          // pc ran off the end of memory; never re-read address 0.
          err_d   = 1'b1;
          state_d = S_HALT;
        end else if (word[8:6] == OP_HALT) begin
          state_d = S_HALT;
        end else if ((word[8:6] == OP_IMM) && (pc_q == 5'd31)) begin
          // An immediate-carrying opcode in the last slot has no operand.
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          run              = 1'b1;
          DIN              = word;
          {wrap_d, pc_d}   = {1'b0, pc_q} + 6'd1;
          cnt_d            = '0;
          state_d          = (word[8:6] == OP_IMM) ? S_IMM : S_WAIT;
        end
      end
      S_IMM: begin
        DIN            = word;
        {wrap_d, pc_d} = {1'b0, pc_q} + 6'd1;
        cnt_d          = '0;
        if (done) begin
          count_inc = 1'b1;
          state_d   = S_ISSUE;
        end else begin
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done) begin
          count_inc = 1'b1;
          state_d   = S_ISSUE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (count_inc && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Control state; reset wins over every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Program memory is never cleared; a write coinciding with reset is dropped.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign pc          = pc_q;
  assign busy        = (state_q == S_ISSUE) || (state_q == S_IMM) || (state_q == S_WAIT);
  assign halted      = (state_q == S_HALT);
  assign err         = err_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: a processor model answers run with done, expected
// DIN words are queued as programs are loaded and compared as they appear.
module tb_instr_feeder;

  localparam int TMO = 7;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load_en = 1'b0;
  logic [4:0] load_addr = '0;
  logic [8:0] load_data = '0;
  logic       start = 1'b0;
  logic       done = 1'b0;
  logic       run;
  logic [8:0] DIN;
  logic [4:0] pc;
  logic       busy;
  logic       halted;
  logic       err;
  logic [7:0] instr_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [8:0] exp_q [$];
  logic [8:0] obs_q [$];
  int         run_cyc [$];
  int         halt_cyc;

  instr_feeder #(.TIMEOUT(TMO)) dut (
    .clock       (clock),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .done        (done),
    .run         (run),
    .DIN         (DIN),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .err         (err),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_word(input logic [4:0] a, input logic [8:0] d);
    @(negedge clock);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clock);
    load_en   = 1'b0;
  endtask

  // Processor model: acknowledges each issued instruction ack_delay cycles
  // after run (0 = never), records every word presented on DIN.
  task automatic run_proc(input int ack_delay, input int budget, output bit to);
    int waitc;
    bit pend_imm;
    waitc = 0;
    pend_imm = 1'b0;
    to = 1'b1;
    obs_q.delete();
    run_cyc.delete();
    halt_cyc = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      start = 1'b0;
      load_en = 1'b0;
      done = 1'b0;
      if (halted) begin
        halt_cyc = c;
        to = 1'b0;
        break;
      end
      if (pend_imm) begin
        obs_q.push_back(DIN);
        pend_imm = 1'b0;
      end
      if (waitc > 0) begin
        waitc--;
        if (waitc == 0) done = 1'b1;
      end
      if (run) begin
        obs_q.push_back(DIN);
        run_cyc.push_back(c);
        pend_imm = (DIN[8:6] == 3'b001);
        waitc = ack_delay;
      end
    end
    done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; done = 1'b1;
    repeat (3) @(negedge clock);
    total_cnt++;
    if ({run, DIN, pc, busy, halted, err, instr_count} !== 26'd0)
      $display("FAIL reset_outputs: got %h, want 0", {run, DIN, pc, busy, halted, err, instr_count});
    else pass_cnt++;
    reset = 1'b0; start = 1'b0; done = 1'b0;
    @(negedge clock);
    total_cnt++;
    if ({run, DIN, busy, halted} !== 12'd0)
      $display("FAIL reset_idle: got %h, want 0", {run, DIN, busy, halted});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    bit to;
    logic [8:0] e, o;
    load_word(5'd0, 9'h040); load_word(5'd1, 9'h005); load_word(5'd2, 9'h008);
    load_word(5'd3, 9'h081); load_word(5'd4, 9'h1C0);
    exp_q = '{9'h040, 9'h005, 9'h008, 9'h081};
    @(negedge clock); start = 1'b1;
    run_proc(1, 50, to);
    total_cnt++;
    if (to) $display("FAIL basic_timeout: no halt within budget");
    else pass_cnt++;
    total_cnt++;
    if (obs_q.size() != exp_q.size()) $display("FAIL basic_words: got %0d words, want %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL basic_din: got %h, want %h", o, e);
      else pass_cnt++;
    end
    exp_q.delete();
    total_cnt++;
    if (run_cyc.size() != 3 || run_cyc[0] != 0 || run_cyc[1] != 2 || run_cyc[2] != 4)
      $display("FAIL basic_latency: got %0d run cycles, first %0d, want runs at 0,2,4", run_cyc.size(), (run_cyc.size() > 0) ? run_cyc[0] : -1);
    else pass_cnt++;
    total_cnt++;
    if (halt_cyc != 7) $display("FAIL basic_halt_cycle: got %0d, want 7", halt_cyc);
    else pass_cnt++;
    total_cnt++;
    if ({halted, err, busy, instr_count, pc} !== {1'b1, 1'b0, 1'b0, 8'd3, 5'd4})
      $display("FAIL basic_final: got halted=%b err=%b busy=%b count=%0d pc=%0d, want 1 0 0 3 4", halted, err, busy, instr_count, pc);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    bit to;
    load_word(5'd0, 9'h00A); load_word(5'd1, 9'h1C0);
    @(negedge clock); start = 1'b1;
    run_proc(0, 40, to);
    total_cnt++;
    if (to) $display("FAIL timeout_timeout: no halt within budget");
    else pass_cnt++;
    total_cnt++;
    if (obs_q.size() != 1 || obs_q[0] !== 9'h00A)
      $display("FAIL timeout_words: got %0d words, want single 00a", obs_q.size());
    else pass_cnt++;
    total_cnt++;
    if (halt_cyc != 1 + TMO) $display("FAIL timeout_cycle: got %0d, want %0d", halt_cyc, 1 + TMO);
    else pass_cnt++;
    total_cnt++;
    if ({halted, err, instr_count, pc} !== {1'b1, 1'b1, 8'd0, 5'd1})
      $display("FAIL timeout_final: got halted=%b err=%b count=%0d pc=%0d, want 1 1 0 1", halted, err, instr_count, pc);
    else pass_cnt++;
  endtask

  task automatic test_wait_edge();
    bit to;
    load_word(5'd0, 9'h00A); load_word(5'd1, 9'h00B); load_word(5'd2, 9'h1C0);
    @(negedge clock); start = 1'b1;
    run_proc(TMO, 60, to);
    total_cnt++;
    if (to) $display("FAIL edge_timeout: no halt within budget");
    else pass_cnt++;
    total_cnt++;
    if (run_cyc.size() != 2 || run_cyc[1] != 1 + TMO)
      $display("FAIL edge_runs: got %0d runs, second at %0d, want 2 runs, second at %0d", run_cyc.size(), (run_cyc.size() > 1) ? run_cyc[1] : -1, 1 + TMO);
    else pass_cnt++;
    total_cnt++;
    if ({err, instr_count, pc} !== {1'b0, 8'd2, 5'd2})
      $display("FAIL edge_final: got err=%b count=%0d pc=%0d, want 0 2 2", err, instr_count, pc);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    bit to;
    logic [8:0] e, o;
    for (int i = 0; i < 32; i++) begin
      load_word(5'(i), 9'h008);
      exp_q.push_back(9'h008);
    end
    @(negedge clock); start = 1'b1;
    run_proc(1, 200, to);
    total_cnt++;
    if (to) $display("FAIL wrap_timeout: no halt within budget");
    else pass_cnt++;
    total_cnt++;
    if (obs_q.size() != exp_q.size()) $display("FAIL wrap_words: got %0d words, want %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL wrap_din: got %h, want %h", o, e);
      else pass_cnt++;
    end
    exp_q.delete();
    total_cnt++;
    if ({halted, err, instr_count, pc} !== {1'b1, 1'b1, 8'd32, 5'd0})
      $display("FAIL wrap_final: got halted=%b err=%b count=%0d pc=%0d, want 1 1 32 0", halted, err, instr_count, pc);
    else pass_cnt++;
  endtask

  task automatic test_imm_at_end();
    bit to;
    for (int i = 0; i < 31; i++) load_word(5'(i), 9'h010);
    load_word(5'd31, 9'h040);
    @(negedge clock); start = 1'b1;
    run_proc(1, 200, to);
    total_cnt++;
    if (to) $display("FAIL immend_timeout: no halt within budget");
    else pass_cnt++;
    total_cnt++;
    if (run_cyc.size() != 31) $display("FAIL immend_runs: got %0d runs, want 31", run_cyc.size());
    else pass_cnt++;
    total_cnt++;
    if ({halted, err, instr_count, pc} !== {1'b1, 1'b1, 8'd31, 5'd31})
      $display("FAIL immend_final: got halted=%b err=%b count=%0d pc=%0d, want 1 1 31 31", halted, err, instr_count, pc);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit to;
    logic [8:0] e, o;
    load_word(5'd0, 9'h081); load_word(5'd1, 9'h1C0);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    total_cnt++;
    if ({run, DIN} !== {1'b1, 9'h081}) $display("FAIL rstmid_issue: got run=%b DIN=%h, want 1 081", run, DIN);
    else pass_cnt++;
    repeat (2) @(negedge clock);
    total_cnt++;
    if ({busy, run} !== 2'b10) $display("FAIL rstmid_wait: got busy=%b run=%b, want 1 0", busy, run);
    else pass_cnt++;
    reset = 1'b1; done = 1'b1;
    @(negedge clock);
    reset = 1'b0; done = 1'b0;
    total_cnt++;
    if ({run, DIN, pc, busy, halted, err, instr_count} !== 26'd0)
      $display("FAIL rstmid_outputs: got %h, want 0", {run, DIN, pc, busy, halted, err, instr_count});
    else pass_cnt++;
    load_word(5'd1, 9'h0C3); load_word(5'd2, 9'h1C0);
    exp_q = '{9'h081, 9'h0C3};
    @(negedge clock); start = 1'b1;
    run_proc(1, 50, to);
    total_cnt++;
    if (to || obs_q.size() != exp_q.size())
      $display("FAIL rstmid_words: got %0d words (timeout=%b), want %0d", obs_q.size(), to, exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL rstmid_din: got %h, want %h", o, e);
      else pass_cnt++;
    end
    exp_q.delete();
    total_cnt++;
    if ({err, instr_count, pc} !== {1'b0, 8'd2, 5'd2})
      $display("FAIL rstmid_final: got err=%b count=%0d pc=%0d, want 0 2 2", err, instr_count, pc);
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    bit to;
    load_word(5'd0, 9'h00A); load_word(5'd1, 9'h00B); load_word(5'd2, 9'h1C0);
    @(negedge clock); start = 1'b1;
    @(negedge clock);
    total_cnt++;
    if ({run, DIN} !== {1'b1, 9'h00A}) $display("FAIL busy_issue: got run=%b DIN=%h, want 1 00a", run, DIN);
    else pass_cnt++;
    start = 1'b1; load_en = 1'b1; load_addr = 5'd1; load_data = 9'h1C0;
    @(negedge clock);
    @(negedge clock);
    start = 1'b0; load_en = 1'b0; done = 1'b1;
    exp_q = '{9'h00B};
    run_proc(1, 50, to);
    total_cnt++;
    if (to || obs_q.size() != 1 || obs_q[0] !== exp_q[0])
      $display("FAIL busy_words: got %0d words first %h (timeout=%b), want single 00b", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 9'h0, to);
    else pass_cnt++;
    exp_q.delete();
    total_cnt++;
    if ({err, instr_count, pc} !== {1'b0, 8'd2, 5'd2})
      $display("FAIL busy_final: got err=%b count=%0d pc=%0d, want 0 2 2", err, instr_count, pc);
    else pass_cnt++;
    @(negedge clock); done = 1'b1;
    repeat (2) @(negedge clock);
    done = 1'b0;
    total_cnt++;
    if ({halted, instr_count} !== {1'b1, 8'd2}) $display("FAIL halt_done_ignored: got halted=%b count=%0d, want 1 2", halted, instr_count);
    else pass_cnt++;
  endtask

  task automatic test_start_with_load();
    bit to;
    load_word(5'd1, 9'h1C0);
    @(negedge clock);
    start = 1'b1; load_en = 1'b1; load_addr = 5'd0; load_data = 9'h00C;
    run_proc(1, 50, to);
    total_cnt++;
    if (to || obs_q.size() != 1 || obs_q[0] !== 9'h00C)
      $display("FAIL startload_words: got %0d words first %h (timeout=%b), want single 00c", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 9'h0, to);
    else pass_cnt++;
    total_cnt++;
    if ({halted, err, instr_count} !== {1'b1, 1'b0, 8'd1})
      $display("FAIL startload_final: got halted=%b err=%b count=%0d, want 1 0 1", halted, err, instr_count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_wait_edge();
    test_wrap();
    test_imm_at_end();
    test_reset_mid();
    test_busy_ignore();
    test_start_with_load();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
